imem_loader: RTL and testbench

- Write-side counterpart of the single-cycle CPU's instruction fetch.
- Accepts a program as a stream of 32-bit words over a valid/ready handshake and writes them into a 1024x32 instruction RAM at sequential addresses from 0.
- Holds the CPU in reset until the load completes.
- Serves the CPU's combinational fetch port from the same RAM.

---
 rtl/imem_loader_pkg.sv | 8 +
 rtl/imem_loader_if.sv | 21 ++
 rtl/imem_loader_ram.sv | 17 +
 rtl/imem_loader.sv | 58 +++++
 tb/tb_imem_loader.sv | 135 +++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared widths and loader state encoding for the instruction memory path
package imem_loader_pkg;
   localparam int ADDR_W = 10;
   localparam int DATA_W = 32;
   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: program stream, fetch port and load status of the instruction loader
interface imem_loader_if;
   import imem_loader_pkg::*;
   logic start;
   logic [ADDR_W:0] load_len;
   logic in_valid;
   logic [DATA_W-1:0] in_data;
   logic in_ready;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_instr;
   logic cpu_rst;
   logic busy;
   logic done;
   logic [ADDR_W:0] wr_count;
   logic [DATA_W-1:0] checksum;
   logic err;
   modport master (output start, load_len, in_valid, in_data, cpu_addr,
                   input in_ready, cpu_instr, cpu_rst, busy, done, wr_count, checksum, err);
   modport slave (input start, load_len, in_valid, in_data, cpu_addr,
                  output in_ready, cpu_instr, cpu_rst, busy, done, wr_count, checksum, err);
endinterface

// File: rtl/imem_loader_ram.sv
// imem_ram: instruction RAM, one synchronous write port and one asynchronous read port, no reset
module imem_ram #(
   parameter int ADDR_W = imem_loader_pkg::ADDR_W,
   parameter int DATA_W = imem_loader_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [1 << ADDR_W];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/imem_loader.sv
// imem_loader: streams a program into instruction RAM and holds the CPU in reset until it is loaded
module imem_loader
   import imem_loader_pkg::*;
(
   input logic clk,
   input logic rst,
   imem_loader_if.slave bus
);
   state_t state, state_n;
   logic [ADDR_W:0] len, wr_count, wr_next;
   logic [DATA_W-1:0] checksum;
   logic err, len_ok, go, bad, xfer;
   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= state_n;
   // start is only honoured outside LOAD; a bad length leaves the state alone
   always_comb begin
      len_ok = bus.load_len != '0 && bus.load_len <= MAX_LEN;
      go = bus.start && len_ok && state != LOAD;
      bad = bus.start && !len_ok && state != LOAD;
      xfer = bus.in_valid && state == LOAD;
      wr_next = wr_count + (ADDR_W+1)'(1);
      state_n = go ? LOAD : (xfer && wr_next == len) ? DONE : state;
      bus.in_ready = state == LOAD;
      bus.busy = state == LOAD;
      bus.done = state == DONE;
      bus.cpu_rst = state != DONE;
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         len <= '0;
         wr_count <= '0;
         checksum <= '0;
         err <= 1'b0;
      end else if (go) begin
         len <= bus.load_len;
         wr_count <= '0;
         checksum <= '0;
         err <= 1'b0;
      end else begin
         if (xfer) begin
            wr_count <= wr_next;
            checksum <= checksum + bus.in_data;
         end
         if (bad) err <= 1'b1;
      end
   assign bus.wr_count = wr_count;
   assign bus.checksum = checksum;
   assign bus.err = err;
   imem_ram #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
      .clk(clk),
      .we(xfer),
      .waddr(wr_count[ADDR_W-1:0]),
      .wdata(bus.in_data),
      .raddr(bus.cpu_addr),
      .rdata(bus.cpu_instr)
   );
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: table-driven check of the loader handshake, status and RAM contents
module tb_imem_loader;
   typedef struct {
      logic r;
      logic st;
      logic [10:0] len;
      logic v;
      logic [31:0] d;
      logic [47:0] exp;
   } vec_t;
   localparam logic [4:0] IDL = 5'b00010, IDL_E = 5'b00011, LD = 5'b11010, DN = 5'b00100, DN_E = 5'b00101;
   localparam logic [31:0] D0 = 32'h20080005, D1 = 32'h20090003, D2 = 32'h01095020, D3 = 32'hAC0A0000;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int tests = 0;
   int fails = 0;
   vec_t vecs[21];
   imem_loader_if bus();
   imem_loader dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic logic [47:0] outs();
      return {bus.in_ready, bus.busy, bus.done, bus.cpu_rst, bus.err, bus.wr_count, bus.checksum};
   endfunction
   function automatic vec_t mk(logic r, logic st, logic [10:0] len, logic v, logic [31:0] d,
                               logic [4:0] f, logic [10:0] wc, logic [31:0] cs);
      vec_t x;
      x.r = r; x.st = st; x.len = len; x.v = v; x.d = d;
      x.exp = {f, wc, cs};
      return x;
   endfunction
   task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
      tests++;
      if (a !== e) begin
         fails++;
         $display("FAIL %s: got %h expected %h", n, a, e);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input string n, input logic [9:0] a, input logic [31:0] e);
      bus.cpu_addr = a;
      #1 chk(n, bus.cpu_instr, e);
   endtask
   initial begin
      bus.start = 1'b0; bus.load_len = '0; bus.in_valid = 1'b0; bus.in_data = '0; bus.cpu_addr = '0;
      #2 rst = 1'b1;
      #1 chk("reset", outs(), {IDL, 11'd0, 32'd0});
      step(); step();
      rst = 1'b0;
      vecs[0]  = mk(0, 1, 4, 0, 0, LD, 0, 0);
      vecs[1]  = mk(0, 0, 0, 1, D0, LD, 1, 32'h20080005);
      vecs[2]  = mk(0, 0, 0, 1, D1, LD, 2, 32'h40110008);
      vecs[3]  = mk(0, 0, 0, 1, D2, LD, 3, 32'h411A5028);
      vecs[4]  = mk(0, 0, 0, 1, D3, DN, 4, 32'hED245028);
      vecs[5]  = mk(0, 0, 0, 1, 32'hDEADBEEF, DN, 4, 32'hED245028);
      vecs[6]  = mk(0, 1, 0, 0, 0, DN_E, 4, 32'hED245028);
      vecs[7]  = mk(0, 1, 4, 0, 0, LD, 0, 0);
      vecs[8]  = mk(0, 0, 0, 1, D0, LD, 1, 32'h20080005);
      vecs[9]  = mk(0, 0, 0, 0, 32'hFFFFFFFF, LD, 1, 32'h20080005);
      vecs[10] = mk(0, 1, 1, 0, 0, LD, 1, 32'h20080005);
      vecs[11] = mk(0, 0, 0, 1, D1, LD, 2, 32'h40110008);
      vecs[12] = mk(0, 0, 0, 0, 32'h12345678, LD, 2, 32'h40110008);
      vecs[13] = mk(0, 0, 0, 1, D2, LD, 3, 32'h411A5028);
      vecs[14] = mk(0, 0, 0, 1, D3, DN, 4, 32'hED245028);
      vecs[15] = mk(0, 1, 1025, 0, 0, DN_E, 4, 32'hED245028);
      vecs[16] = mk(1, 0, 0, 0, 0, IDL, 0, 0);
      vecs[17] = mk(0, 1, 0, 0, 0, IDL_E, 0, 0);
      vecs[18] = mk(0, 1, 1025, 0, 0, IDL_E, 0, 0);
      vecs[19] = mk(0, 1, 1, 0, 0, LD, 0, 0);
      vecs[20] = mk(0, 0, 0, 1, D0, DN, 1, 32'h20080005);
      foreach (vecs[i]) begin
         rst = vecs[i].r;
         bus.start = vecs[i].st;
         bus.load_len = vecs[i].len;
         bus.in_valid = vecs[i].v;
         bus.in_data = vecs[i].d;
         step();
         chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
      end
      bus.start = 1'b0; bus.in_valid = 1'b0;
      rd("mem0", 0, D0);
      rd("mem1", 1, D1);
      rd("mem2", 2, D2);
      rd("mem3", 3, D3);
      bus.start = 1'b1; bus.load_len = 11'd1024;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'(i);
         step();
      end
      bus.in_valid = 1'b0;
      chk("full_status", outs(), {DN, 11'd1024, 32'h0007FE00});
      rd("full_mem1023", 10'd1023, 32'd1023);
      rd("full_mem512", 10'd512, 32'd512);
      bus.start = 1'b1; bus.load_len = 11'd2;
      step();
      bus.start = 1'b0;
      chk("reload_cpu_rst", outs(), {LD, 11'd0, 32'd0});
      bus.cpu_addr = 10'd0; bus.in_valid = 1'b1; bus.in_data = 32'h11111111;
      #1 chk("same_cycle_old", bus.cpu_instr, 32'd0);
      step();
      chk("same_cycle_new", bus.cpu_instr, 32'h11111111);
      bus.in_data = 32'h22222222;
      step();
      bus.in_valid = 1'b0;
      chk("reload_status", outs(), {DN, 11'd2, 32'h33333333});
      rd("reload_mem1", 1, 32'h22222222);
      rd("reload_mem2", 2, 32'd2);
      bus.start = 1'b1; bus.load_len = 11'd8;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'hC0 + 32'(i);
         step();
      end
      bus.in_valid = 1'b0;
      chk("midload_pre", outs(), {LD, 11'd3, 32'h243});
      #2 rst = 1'b1;
      #1 chk("midload_rst", outs(), {IDL, 11'd0, 32'd0});
      step();
      rst = 1'b0;
      step();
      chk("midload_after", outs(), {IDL, 11'd0, 32'd0});
      rd("midload_mem0", 0, 32'hC0);
      rd("midload_mem1", 1, 32'hC1);
      rd("midload_mem2", 2, 32'hC2);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
